// File: rtl/int_issue_pipe_if.sv
// ============================================================================
// int_issue_pipe_if
//   Valid/ready payload channel used on both sides of int_issue_pipe.
//
//   Signals:
//     data   payload (DATA_WIDTH bits), driven by the producer
//     valid  payload valid, driven by the producer
//     ready  consumer can accept this cycle, driven by the consumer
//
//   Modports:
//     master  producer side (drives data/valid, samples ready)
//     slave   consumer side (samples data/valid, drives ready)
// ============================================================================
interface int_issue_pipe_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] data;
    logic                  valid;
    logic                  ready;

    modport master (
        output data,
        output valid,
        input  ready
    );

    modport slave (
        input  data,
        input  valid,
        output ready
    );
endinterface

// File: rtl/int_issue_pipe.sv
// ============================================================================
// int_issue_pipe
//   Registered issue stage between the integer issue queue dequeue port and
//   the integer execution unit. Holds the selected instruction in a main
//   register M (optionally backed by a skid register S) and kills held or
//   incoming instructions younger than a redirect's ROB id.
//
//   Build option:
//     INT_ISSUE_SKID_EN  defined   -> M + S, registered isq_deq.ready,
//                                     occupancy 0..2
//                        undefined -> M only, isq_deq.ready passes exu
//                                     backpressure through, occupancy 0..1
//
//   Ports:
//     clock        single clock
//     reset_n      asynchronous active-low reset
//     isq_deq      slave channel from the issue queue (data/valid in, ready out)
//     exu          master channel to the execution unit (data/valid out, ready in)
//     flush_valid  redirect this cycle
//     flush_robid  ROB id of the redirecting instruction (it survives)
//     occupancy    number of held entries
//
//   The ROB id lives at data[ROBID_LSB +: INSTR_ID_WIDTH+1]; its MSB is the
//   wrap bit.
// ============================================================================
module int_issue_pipe #(
    parameter int unsigned ISQ_DATA_WIDTH = 32,
    parameter int unsigned DATA_WIDTH     = ISQ_DATA_WIDTH,
    parameter int unsigned INSTR_ID_WIDTH = 5,
    parameter int unsigned ROBID_LSB      = 0
) (
    input  logic                    clock,
    input  logic                    reset_n,
    int_issue_pipe_if.slave         isq_deq,
    int_issue_pipe_if.master        exu,
    input  logic                    flush_valid,
    input  logic [INSTR_ID_WIDTH:0] flush_robid,
    output logic [1:0]              occupancy
);

    localparam int unsigned ID_W = INSTR_ID_WIDTH + 1;

    typedef logic [ID_W-1:0]       robid_t;
    typedef logic [DATA_WIDTH-1:0] data_t;

`ifdef INT_ISSUE_SKID_EN
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } occ_e;
`else
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1
    } occ_e;
`endif

    // Age compare across the wrap bit: with matching wrap bits the larger
    // index is younger; with differing wrap bits the smaller index is.
    function automatic logic is_younger(input robid_t e, input robid_t f);
        if (e[ID_W-1] == f[ID_W-1]) begin
            return e[ID_W-2:0] > f[ID_W-2:0];
        end
        return e[ID_W-2:0] < f[ID_W-2:0];
    endfunction

    function automatic robid_t robid_of(input data_t d);
        return d[ROBID_LSB +: ID_W];
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic  m_valid_q, m_valid_d;
    data_t m_data_q,  m_data_d;
    occ_e  state_q,   state_d;

`ifdef INT_ISSUE_SKID_EN
    logic  s_valid_q, s_valid_d;
    data_t s_data_q,  s_data_d;
    logic  ready_q,   ready_d;
`endif

    logic isq_ready;
    logic enq_fire;
    logic enq_ok;
    logic deq_fire;
    logic m_keep;
    logic s_keep;

`ifdef INT_ISSUE_SKID_EN
    // Pure flop output: the issue queue never sees exu backpressure
    // combinationally.
    assign isq_ready = ready_q;
`else
    assign isq_ready = !m_valid_q || exu.ready;
`endif

    assign isq_deq.ready = isq_ready;
    assign exu.valid     = m_valid_q;
    assign exu.data      = m_data_q;
    assign occupancy     = state_q;

    // ------------------------------------------------------------------
    // Next state
    //   Survivors are compacted in age order: M (if it stays), then S,
    //   then the incoming beat. This covers every occupancy transition
    //   plus flush kills and S->M promotion in one rule. The enqueue
    //   cannot coincide with a surviving S because ready is low while S
    //   is valid, so at most two survivors exist.
    // ------------------------------------------------------------------
    always_comb begin
        enq_fire = isq_deq.valid && isq_ready;
        enq_ok   = enq_fire &&
                   !(flush_valid && is_younger(robid_of(isq_deq.data), flush_robid));
        deq_fire = m_valid_q && exu.ready;

        // A dequeuing M leaves regardless of the flush, so it is counted once.
        m_keep   = m_valid_q && !deq_fire &&
                   !(flush_valid && is_younger(robid_of(m_data_q), flush_robid));
`ifdef INT_ISSUE_SKID_EN
        s_keep   = s_valid_q &&
                   !(flush_valid && is_younger(robid_of(s_data_q), flush_robid));
`else
        s_keep   = 1'b0;
`endif

        m_valid_d = 1'b0;
        m_data_d  = m_data_q;
        if (m_keep) begin
            m_valid_d = 1'b1;
`ifdef INT_ISSUE_SKID_EN
        end else if (s_keep) begin
            m_valid_d = 1'b1;
            m_data_d  = s_data_q;
`endif
        end else if (enq_ok) begin
            m_valid_d = 1'b1;
            m_data_d  = isq_deq.data;
        end

`ifdef INT_ISSUE_SKID_EN
        s_valid_d = 1'b0;
        s_data_d  = s_data_q;
        if (m_keep && s_keep) begin
            s_valid_d = 1'b1;
        end else if ((m_keep || s_keep) && enq_ok) begin
            s_valid_d = 1'b1;
            s_data_d  = isq_deq.data;
        end
        ready_d = !s_valid_d;

        if (s_valid_d) begin
            state_d = FULL;
        end else if (m_valid_d) begin
            state_d = ONE;
        end else begin
            state_d = EMPTY;
        end
`else
        state_d = m_valid_d ? ONE : EMPTY;
`endif
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            state_q   <= EMPTY;
`ifdef INT_ISSUE_SKID_EN
            s_valid_q <= 1'b0;
            s_data_q  <= '0;
            ready_q   <= 1'b1;
`endif
        end else begin
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            state_q   <= state_d;
`ifdef INT_ISSUE_SKID_EN
            s_valid_q <= s_valid_d;
            s_data_q  <= s_data_d;
            ready_q   <= ready_d;
`endif
        end
    end

endmodule

// File: tb/tb_int_issue_pipe.sv
// ============================================================================
// tb_int_issue_pipe
//   Scoreboard bench for int_issue_pipe. The driver keeps the list of
//   instructions that should be held in the stage (oldest first); a
//   separate monitor compares the DUT outputs against it every cycle and
//   retires the head when the execution unit accepts it.
// ============================================================================
module tb_int_issue_pipe;

    localparam int unsigned DW  = 32;
    localparam int unsigned IW  = 5;
    localparam int unsigned IDW = IW + 1;
    localparam int unsigned LSB = 4;

`ifdef INT_ISSUE_SKID_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    logic           clock;
    logic           reset_n;
    logic           flush_valid;
    logic [IDW-1:0] flush_robid;
    logic [1:0]     occupancy;

    int_issue_pipe_if #(.DATA_WIDTH(DW)) isq_if ();
    int_issue_pipe_if #(.DATA_WIDTH(DW)) exu_if ();

    int_issue_pipe #(
        .ISQ_DATA_WIDTH(DW),
        .DATA_WIDTH    (DW),
        .INSTR_ID_WIDTH(IW),
        .ROBID_LSB     (LSB)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .isq_deq    (isq_if),
        .exu        (exu_if),
        .flush_valid(flush_valid),
        .flush_robid(flush_robid),
        .occupancy  (occupancy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;
    logic [DW-1:0] exp_q[$];
    int unsigned next_id = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [IDW-1:0] id_of(input logic [DW-1:0] d);
        return d[LSB +: IDW];
    endfunction

    // ROB ids form a modular counter; e is younger than f when it lies
    // strictly within the forward half-window after f.
    function automatic bit m_younger(input logic [IDW-1:0] e, input logic [IDW-1:0] f);
        int diff;
        diff = (int'(e) - int'(f)) & ((1 << IDW) - 1);
        return (diff >= 1) && (diff <= (1 << IW) - 1);
    endfunction

    function automatic bit model_ready(input bit er);
        if (CAP == 2) return exp_q.size() < 2;
        return (exp_q.size() == 0) || er;
    endfunction

    function automatic logic [DW-1:0] mk(input int unsigned id);
        logic [DW-1:0]  d;
        logic [IDW-1:0] idv;
        idv = IDW'(id);
        d   = $urandom;
        d[LSB +: IDW] = idv;
        return d;
    endfunction

    // ------------------------------------------------------------------
    // Monitor: compares DUT outputs with the expected held list before
    // the coming edge and retires the head on an accepted dequeue.
    // ------------------------------------------------------------------
    always @(negedge clock) begin
        if (reset_n) begin
            check("exu_valid", 32'(exu_if.valid), 32'(exp_q.size() != 0));
            check("occupancy", 32'(occupancy), 32'(exp_q.size()));
            check("isq_ready", 32'(isq_if.ready), 32'(model_ready(exu_if.ready)));
            if (exu_if.valid && exp_q.size() != 0) begin
                check("exu_data", exu_if.data, exp_q[0]);
            end
            if (exp_q.size() != 0 && exu_if.ready) begin
                void'(exp_q.pop_front());
            end
        end
    end

    // ------------------------------------------------------------------
    // Driver: one cycle of stimulus, then the model update for the edge.
    // ------------------------------------------------------------------
    task automatic step(input bit v, input logic [DW-1:0] d, input bit er,
                        input bit fv, input logic [IDW-1:0] fid);
        bit acc;
        logic [DW-1:0] keep_q[$];
        @(posedge clock);
        #1;
        isq_if.valid  = v;
        isq_if.data   = d;
        exu_if.ready  = er;
        flush_valid   = fv;
        flush_robid   = fid;
        acc = v && model_ready(er);
        @(negedge clock);
        #1;
        if (fv) begin
            foreach (exp_q[i]) begin
                if (!m_younger(id_of(exp_q[i]), fid)) keep_q.push_back(exp_q[i]);
            end
            exp_q = keep_q;
        end
        if (acc && !(fv && m_younger(id_of(d), fid))) begin
            exp_q.push_back(d);
        end
    endtask

    task automatic idle(input bit er, input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, er, 1'b0, '0);
    endtask

    task automatic reset_now();
        @(posedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_exu_valid", 32'(exu_if.valid), 32'd0);
        check("rst_occupancy", 32'(occupancy), 32'd0);
        check("rst_exu_data", exu_if.data, 32'd0);
        check("rst_isq_ready", 32'(isq_if.ready), 32'd1);
        exp_q.delete();
        isq_if.valid = 1'b0;
        flush_valid  = 1'b0;
        exu_if.ready = 1'b0;
        @(posedge clock);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n      = 1'b0;
        isq_if.valid = 1'b0;
        isq_if.data  = '0;
        exu_if.ready = 1'b0;
        flush_valid  = 1'b0;
        flush_robid  = '0;
        #1;
        check("init_exu_valid", 32'(exu_if.valid), 32'd0);
        check("init_occupancy", 32'(occupancy), 32'd0);
        check("init_exu_data", exu_if.data, 32'd0);
        check("init_isq_ready", 32'(isq_if.ready), 32'd1);
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;

        // Streaming ids 0..7 with the execution unit always ready.
        for (int i = 0; i < 8; i++) step(1'b1, mk(i), 1'b1, 1'b0, '0);
        idle(1'b1, 3);

        // Backpressure: ids 3 and 4 held, then released.
        step(1'b1, mk(3), 1'b0, 1'b0, '0);
        step(1'b1, mk(4), 1'b0, 1'b0, '0);
        idle(1'b0, 2);
        idle(1'b1, 3);

        // Partial flush: M=5, S=9, redirect at 6.
        step(1'b1, mk(5), 1'b0, 1'b0, '0);
        step(1'b1, mk(9), 1'b0, 1'b0, '0);
        step(1'b0, '0, 1'b0, 1'b1, 6'd6);
        idle(1'b0, 1);
        idle(1'b1, 3);

        // Wrap: M={1,1}, incoming {1,2}, redirect {0,30} kills both.
        step(1'b1, mk(33), 1'b0, 1'b0, '0);
        step(1'b1, mk(34), 1'b0, 1'b1, 6'd30);
        idle(1'b0, 1);
        // Redirect equal to the held id keeps it; idx 0 vs max across wrap.
        step(1'b1, mk(32), 1'b0, 1'b0, '0);
        step(1'b0, '0, 1'b0, 1'b1, 6'd32);
        step(1'b0, '0, 1'b0, 1'b1, 6'd31);
        step(1'b0, '0, 1'b0, 1'b1, 6'd63);
        idle(1'b1, 3);

        // Same-cycle dequeue of id 2, incoming id 7, redirect at 4.
        step(1'b1, mk(2), 1'b0, 1'b0, '0);
        step(1'b1, mk(7), 1'b1, 1'b1, 6'd4);
        idle(1'b0, 2);

        // Reset mid-operation with the stage loaded.
        step(1'b1, mk(10), 1'b0, 1'b0, '0);
        step(1'b1, mk(11), 1'b0, 1'b0, '0);
        idle(1'b0, 1);
        reset_now();
        step(1'b1, mk(12), 1'b1, 1'b0, '0);
        idle(1'b1, 2);

        // Randomized traffic with redirects aimed near held ids.
        next_id = 13;
        for (int i = 0; i < 500; i++) begin
            bit v, er, fv;
            logic [IDW-1:0] fid;
            logic [DW-1:0]  d;
            v  = ($urandom_range(0, 9) < 7);
            er = ($urandom_range(0, 9) < 6);
            fv = ($urandom_range(0, 9) == 0);
            if (exp_q.size() != 0 && $urandom_range(0, 1) == 1) begin
                fid = id_of(exp_q[$urandom_range(0, exp_q.size() - 1)]) +
                      IDW'($urandom_range(0, 2)) - IDW'(1);
            end else begin
                fid = IDW'($urandom);
            end
            d = mk(next_id);
            if (v) next_id = (next_id + 1) % (1 << IDW);
            step(v, d, er, fv, fid);
        end
        idle(1'b1, 4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
